// File: rtl/param_ping_pong_counter_gen2.sv
// param_ping_pong_counter_gen2: tick-paced bounded counter with ping-pong, wrap, one-shot and hold modes.
// A direction flip applies immediately; out only moves on ticks while enable is high.
module param_ping_pong_counter_gen2 #(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic             clk_origin,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             flip,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] max,
    input  logic [WIDTH-1:0] min,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] out,
    output logic             direction,
    output logic             tick,
    output logic             done,
    output logic             at_bound
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] PRE  = CW'(TICK_DIV - 2);
    localparam logic [1:0] PING_PONG = 2'b00, WRAP = 2'b01, ONE_SHOT = 2'b10, HOLD = 2'b11;

    logic [CW-1:0]    cnt;
    logic [1:0]       mode_q;
    logic [WIDTH:0]   up_sum, lo_sum;
    logic [WIDTH-1:0] dn_dif, nxt_out;
    logic             d_eff, step_en, top_hit, bot_hit, held, nxt_dir, nxt_done;

    assign step_en  = tick & enable;
    assign at_bound = (out == max) || (out == min);

    // Reaching min while descending reverses, mirroring the up rule at max.
    always_comb begin
        d_eff    = direction ^ flip;
        up_sum   = {1'b0, out} + {1'b0, step};
        lo_sum   = {1'b0, min} + {1'b0, step};
        dn_dif   = out - step;
        top_hit  = up_sum >= {1'b0, max};
        bot_hit  = {1'b0, out} <= lo_sum;
        held     = done & ~flip & (mode == mode_q);
        nxt_out  = out;
        nxt_dir  = d_eff;
        nxt_done = done & ~flip;
        if (step_en) begin
            nxt_done = held & (mode == ONE_SHOT);
            if (out > max || out < min) begin
                nxt_out  = min;
                nxt_dir  = 1'b1;
                nxt_done = 1'b0;
            end else if (max > min && step != '0 && mode != HOLD) begin
                if (mode == PING_PONG) begin
                    nxt_out = d_eff ? (top_hit ? max : up_sum[WIDTH-1:0]) : (bot_hit ? min : dn_dif);
                    nxt_dir = d_eff ? ~top_hit : bot_hit;
                end else if (mode == WRAP) begin
                    nxt_out = d_eff ? (up_sum > {1'b0, max} ? min : up_sum[WIDTH-1:0])
                                    : ({1'b0, out} < lo_sum ? max : dn_dif);
                end else if (!held) begin
                    nxt_out  = d_eff ? (top_hit ? max : up_sum[WIDTH-1:0]) : (bot_hit ? min : dn_dif);
                    nxt_done = d_eff ? top_hit : bot_hit;
                end
            end
        end
    end

    always_ff @(posedge clk_origin or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            tick      <= 1'b0;
            out       <= '0;
            direction <= 1'b1;
            done      <= 1'b0;
            mode_q    <= '0;
        end else begin
            cnt       <= (cnt == LAST) ? '0 : cnt + 1'b1;
            tick      <= cnt == PRE;
            out       <= nxt_out;
            direction <= nxt_dir;
            done      <= nxt_done;
            if (step_en) mode_q <= mode;
        end
    end
endmodule

// File: tb/tb_param_ping_pong_counter_gen2.sv
// tb_param_ping_pong_counter_gen2: directed scenarios plus randomized run against a rule-level model.
module tb_param_ping_pong_counter_gen2;
    localparam int W = 4, TD = 4;

    logic clk = 0, rst_n = 1, enable = 1, flip = 0;
    logic [1:0] mode = 0;
    logic [W-1:0] max = 0, min = 0, step = 0;
    logic [W-1:0] out;
    logic direction, tick, done, at_bound;
    int checks = 0, passes = 0;

    typedef struct { int cnt; int out; bit dir; bit done; int mode; } model_t;
    model_t m;

    param_ping_pong_counter_gen2 #(.WIDTH(W), .TICK_DIV(TD)) dut (
        .clk_origin(clk), .rst_n(rst_n), .enable(enable), .flip(flip), .mode(mode),
        .max(max), .min(min), .step(step), .out(out), .direction(direction),
        .tick(tick), .done(done), .at_bound(at_bound)
    );

    always #5 clk = ~clk;

    function automatic model_t next_model(model_t s, bit en, bit fl, int md, int mx, int mn, int st);
        model_t n = s;
        bit d = s.dir ^ fl;
        n.cnt = (s.cnt + 1) % TD;
        n.done = s.done && !fl;
        if (s.cnt == TD - 1 && en) begin
            n.done = (md == 2 && md == s.mode) ? (s.done && !fl) : 1'b0;
            n.mode = md;
            if (s.out > mx || s.out < mn) begin
                n.out = mn;
                d = 1;
                n.done = 0;
            end else if (mx > mn && st != 0 && md != 3) begin
                if (md == 0) begin
                    if (d) begin
                        n.out = (s.out + st >= mx) ? mx : s.out + st;
                        d = !(s.out + st >= mx);
                    end else begin
                        n.out = (s.out - st <= mn) ? mn : s.out - st;
                        d = (s.out - st <= mn);
                    end
                end else if (md == 1) begin
                    if (d) n.out = (s.out + st > mx) ? mn : s.out + st;
                    else   n.out = (s.out - st < mn) ? mx : s.out - st;
                end else if (!n.done) begin
                    if (d) begin
                        n.out = (s.out + st >= mx) ? mx : s.out + st;
                        n.done = (s.out + st >= mx);
                    end else begin
                        n.out = (s.out - st <= mn) ? mn : s.out - st;
                        n.done = (s.out - st <= mn);
                    end
                end
            end
        end
        n.dir = d;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n)
        if (!rst_n) m <= '{0, 0, 1'b1, 1'b0, 0};
        else m <= next_model(m, enable, flip, int'(mode), int'(max), int'(min), int'(step));

    task automatic do_reset();
        rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic setup(input logic [1:0] md, input int mn, input int mx, input int st);
        mode = md; min = W'(mn); max = W'(mx); step = W'(st); enable = 1; flip = 0;
        do_reset();
    endtask

    task automatic wait_tick();
        int n = 0;
        @(negedge clk);
        while (tick !== 1'b1 && n < 2 * TD) begin
            @(negedge clk);
            n++;
        end
        if (tick !== 1'b1) begin
            checks++;
            $display("FAIL tick_timeout got tick=%b want 1", tick);
        end
    endtask

    task automatic next_tick();
        wait_tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        int first = 0, ticks = 0;
        mode = 0; min = 2; max = 5; step = 1; enable = 1; flip = 0;
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        checks++; if (out !== '0) $display("FAIL rst_out got %0d want 0", out); else passes++;
        checks++; if (direction !== 1'b1) $display("FAIL rst_dir got %b want 1", direction); else passes++;
        checks++; if (tick !== 1'b0) $display("FAIL rst_tick got %b want 0", tick); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else passes++;
        @(negedge clk);
        rst_n = 1;
        for (int i = 1; i <= TD + 2 && first == 0; i++) begin
            @(negedge clk);
            if (tick === 1'b1) first = i;
        end
        checks++; if (first != TD - 1) $display("FAIL first_tick got %0d want %0d", first, TD - 1); else passes++;
        for (int i = 0; i < 4 * TD; i++) begin
            @(negedge clk);
            ticks += int'(tick === 1'b1);
        end
        checks++; if (ticks != 4) $display("FAIL tick_rate got %0d want 4", ticks); else passes++;
    endtask

    task automatic test_pingpong();
        int eo [2][8] = '{'{2, 3, 4, 5, 4, 3, 2, 3}, '{1, 4, 7, 10, 7, 4, 1, 4}};
        bit ed [8] = '{1, 1, 1, 0, 0, 0, 1, 1};
        int lo [2] = '{2, 1};
        int hi [2] = '{5, 10};
        int st [2] = '{1, 3};
        for (int c = 0; c < 2; c++) begin
            setup(2'b00, lo[c], hi[c], st[c]);
            for (int i = 0; i < 8; i++) begin
                next_tick();
                checks++; if (out !== W'(eo[c][i])) $display("FAIL pp%0d_out[%0d] got %0d want %0d", c, i, out, eo[c][i]); else passes++;
                checks++; if (direction !== ed[i]) $display("FAIL pp%0d_dir[%0d] got %b want %b", c, i, direction, ed[i]); else passes++;
                checks++; if (at_bound !== (eo[c][i] == lo[c] || eo[c][i] == hi[c]))
                    $display("FAIL pp%0d_at_bound[%0d] got %b want %b", c, i, at_bound, eo[c][i] == lo[c] || eo[c][i] == hi[c]);
                else passes++;
            end
        end
    endtask

    task automatic test_wrap();
        int up_exp [3] = '{4, 8, 0};
        int dn_exp [4] = '{9, 5, 1, 9};
        setup(2'b01, 0, 9, 4);
        for (int i = 0; i < 3; i++) begin
            next_tick();
            checks++; if (out !== W'(up_exp[i])) $display("FAIL wrap_up[%0d] got %0d want %0d", i, out, up_exp[i]); else passes++;
        end
        flip = 1;
        @(negedge clk);
        flip = 0;
        checks++; if (direction !== 1'b0) $display("FAIL wrap_flip_dir got %b want 0", direction); else passes++;
        for (int i = 0; i < 4; i++) begin
            next_tick();
            checks++; if (out !== W'(dn_exp[i])) $display("FAIL wrap_dn[%0d] got %0d want %0d", i, out, dn_exp[i]); else passes++;
            checks++; if (direction !== 1'b0) $display("FAIL wrap_dn_dir[%0d] got %b want 0", i, direction); else passes++;
        end
    endtask

    task automatic test_flip();
        setup(2'b00, 0, 9, 1);
        repeat (3) next_tick();
        checks++; if (out !== 4'd3) $display("FAIL flip_pre got %0d want 3", out); else passes++;
        @(negedge clk);
        flip = 1;
        @(negedge clk);
        flip = 0;
        checks++; if (direction !== 1'b0) $display("FAIL flip_dir got %b want 0", direction); else passes++;
        checks++; if (out !== 4'd3) $display("FAIL flip_hold got %0d want 3", out); else passes++;
        next_tick();
        checks++; if (out !== 4'd2) $display("FAIL flip_step got %0d want 2", out); else passes++;
        flip = 1;
        @(negedge clk);
        flip = 0;
        next_tick();
        checks++; if (out !== 4'd3 || direction !== 1'b1) $display("FAIL flip_back got %0d/%b want 3/1", out, direction); else passes++;
        wait_tick();
        flip = 1;
        @(negedge clk);
        flip = 0;
        checks++; if (out !== 4'd2 || direction !== 1'b0) $display("FAIL flip_on_tick got %0d/%b want 2/0", out, direction); else passes++;
    endtask

    task automatic test_oneshot();
        int eo [6] = '{2, 3, 3, 1, 0, 0};
        bit ed [6] = '{0, 1, 1, 0, 1, 1};
        setup(2'b10, 0, 3, 2);
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                flip = 1;
                @(negedge clk);
                flip = 0;
                checks++; if (done !== 1'b0 || direction !== 1'b0) $display("FAIL os_flip got done=%b dir=%b want 0/0", done, direction); else passes++;
            end
            next_tick();
            checks++; if (out !== W'(eo[i])) $display("FAIL os_out[%0d] got %0d want %0d", i, out, eo[i]); else passes++;
            checks++; if (done !== ed[i]) $display("FAIL os_done[%0d] got %b want %b", i, done, ed[i]); else passes++;
        end
        mode = 2'b00;
        next_tick();
        checks++; if (done !== 1'b0) $display("FAIL os_mode_change got %b want 0", done); else passes++;
    endtask

    task automatic test_async_reset();
        setup(2'b00, 0, 9, 1);
        repeat (7) next_tick();
        checks++; if (out !== 4'd7) $display("FAIL ar_pre got %0d want 7", out); else passes++;
        #2 rst_n = 0;
        #1;
        checks++; if (out !== '0 || direction !== 1'b1 || done !== 1'b0)
            $display("FAIL ar_now got out=%0d dir=%b done=%b want 0/1/0", out, direction, done);
        else passes++;
        max = 4; min = 4;
        @(negedge clk);
        rst_n = 1;
        next_tick();
        checks++; if (out !== 4'd4) $display("FAIL ar_load got %0d want 4", out); else passes++;
        next_tick();
        checks++; if (out !== 4'd4) $display("FAIL ar_hold got %0d want 4", out); else passes++;
    endtask

    task automatic test_random();
        setup(2'b00, 2, 12, 1);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            checks++; if (out !== W'(m.out)) $display("FAIL rnd_out @%0d got %0d want %0d", i, out, m.out); else passes++;
            checks++; if (direction !== m.dir) $display("FAIL rnd_dir @%0d got %b want %b", i, direction, m.dir); else passes++;
            checks++; if (tick !== (m.cnt == TD - 1)) $display("FAIL rnd_tick @%0d got %b want %b", i, tick, m.cnt == TD - 1); else passes++;
            checks++; if (done !== m.done) $display("FAIL rnd_done @%0d got %b want %b", i, done, m.done); else passes++;
            checks++; if (at_bound !== (m.out == int'(max) || m.out == int'(min)))
                $display("FAIL rnd_at_bound @%0d got %b want %b", i, at_bound, m.out == int'(max) || m.out == int'(min));
            else passes++;
            enable = ($urandom_range(0, 7) != 0);
            flip = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) begin
                min = 4'($urandom_range(0, 8));
                max = 4'($urandom_range(0, 15));
                step = 4'($urandom_range(0, 6));
            end
            if ($urandom_range(0, 999) == 0) begin
                #2 rst_n = 0;
                #1 rst_n = 1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_pingpong();
        test_wrap();
        test_flip();
        test_oneshot();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
